// File: rtl/branch_target_buffer.sv
`default_nettype none
// ============================================================================
// Module   : branch_target_buffer
// Brief    : Direct-mapped BTB with 2-bit predictors and mispredict counter.
// Revision : 1.0
// ============================================================================
module branch_target_buffer #(
    parameter int ENTRIES = 16,
    parameter int INDEX_W = $clog2(ENTRIES),
    parameter int ADDR_W  = 32,
    parameter int CNT_W   = 16
) (
    input  logic              btb_clk,
    input  logic              btb_rst,
    input  logic              btb_lookup_valid,
    input  logic [ADDR_W-1:0] btb_lookup_pc,
    output logic              btb_hit,
    output logic              btb_predict_taken,
    output logic [ADDR_W-1:0] btb_predict_target,
    input  logic              btb_update_valid,
    input  logic [ADDR_W-1:0] btb_update_pc,
    input  logic              btb_update_taken,
    input  logic [ADDR_W-1:0] btb_update_target,
    output logic              btb_mispredict,
    output logic [CNT_W-1:0]  btb_mispredict_count
);

    localparam int         TAG_W        = ADDR_W - INDEX_W - 2;
    localparam logic [1:0] C_CTR_RESET  = 2'b01;
    localparam logic [1:0] C_CTR_ALLOC  = 2'b10;

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [ADDR_W-1:0] target_q [ENTRIES];
    logic [1:0]        ctr_q    [ENTRIES];

    logic              hit_q, hit_d;
    logic              taken_q, taken_d;
    logic [ADDR_W-1:0] ptarget_q, ptarget_d;
    logic              mispredict_q, mispredict_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [INDEX_W-1:0] w_lk_idx, w_up_idx;
    logic [TAG_W-1:0]   w_lk_tag, w_up_tag;
    logic               w_up_hit;
    logic [1:0]         w_up_ctr;
    logic [1:0]         w_up_ctr_d;
    logic               w_unused;

    assign w_lk_idx = btb_lookup_pc[INDEX_W+1:2];
    assign w_lk_tag = btb_lookup_pc[ADDR_W-1:INDEX_W+2];
    assign w_up_idx = btb_update_pc[INDEX_W+1:2];
    assign w_up_tag = btb_update_pc[ADDR_W-1:INDEX_W+2];
    assign w_unused = ^{btb_lookup_pc[1:0], btb_update_pc[1:0]};

    // Lookup reads the table before this edge's update lands (no bypass).
    always_comb begin
        hit_d     = btb_lookup_valid && valid_q[w_lk_idx] && (tag_q[w_lk_idx] == w_lk_tag);
        taken_d   = hit_d && ctr_q[w_lk_idx][1];
        ptarget_d = hit_d ? target_q[w_lk_idx] : '0;
    end

    always_comb begin
        w_up_hit = valid_q[w_up_idx] && (tag_q[w_up_idx] == w_up_tag);
        w_up_ctr = ctr_q[w_up_idx];
        if (btb_update_taken)
            w_up_ctr_d = (w_up_ctr == 2'b11) ? 2'b11 : w_up_ctr + 2'd1;
        else
            w_up_ctr_d = (w_up_ctr == 2'b00) ? 2'b00 : w_up_ctr - 2'd1;

        mispredict_d = 1'b0;
        if (btb_update_valid) begin
            if (!w_up_hit)
                mispredict_d = btb_update_taken;
            else
                mispredict_d = (w_up_ctr[1] != btb_update_taken) ||
                               (w_up_ctr[1] && btb_update_taken &&
                                (target_q[w_up_idx] != btb_update_target));
        end

        count_d = count_q;
        if (mispredict_d && (count_q != {CNT_W{1'b1}}))
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge btb_clk or posedge btb_rst) begin
        if (btb_rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= C_CTR_RESET;
            end
        end else if (btb_update_valid) begin
            if (w_up_hit) begin
                ctr_q[w_up_idx] <= w_up_ctr_d;
                if (btb_update_taken)
                    target_q[w_up_idx] <= btb_update_target;
            end else if (btb_update_taken) begin
                valid_q[w_up_idx]  <= 1'b1;
                tag_q[w_up_idx]    <= w_up_tag;
                target_q[w_up_idx] <= btb_update_target;
                ctr_q[w_up_idx]    <= C_CTR_ALLOC;
            end
        end
    end

    always_ff @(posedge btb_clk or posedge btb_rst) begin
        if (btb_rst) begin
            hit_q        <= 1'b0;
            taken_q      <= 1'b0;
            ptarget_q    <= '0;
            mispredict_q <= 1'b0;
            count_q      <= '0;
        end else begin
            hit_q        <= hit_d;
            taken_q      <= taken_d;
            ptarget_q    <= ptarget_d;
            mispredict_q <= mispredict_d;
            count_q      <= count_d;
        end
    end

    assign btb_hit              = hit_q;
    assign btb_predict_taken    = taken_q;
    assign btb_predict_target   = ptarget_q;
    assign btb_mispredict       = mispredict_q;
    assign btb_mispredict_count = count_q;

endmodule
`default_nettype wire
